// File: rtl/block_move_multi.sv
// Multi-slot falling-block engine: tick divider, spawn pattern, per-slot fall/judge FSM and scoring.
// Optional KEY_EDGE_EN: judge on latched key presses instead of held key levels.
module block_move_multi #(
  parameter int unsigned NUM_KEYS    = 16,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned COORD_W     = 16,
  parameter int unsigned X_ORIGIN    = 163,
  parameter int unsigned X_PITCH     = 40,
  parameter int unsigned Y_START     = 5,
  parameter int unsigned Y_HIT       = 305,
  parameter int unsigned Y_STEP      = 2,
  parameter int unsigned TICK_BASE   = 250000,
  parameter int unsigned SPAWN_GAP   = 40,
  parameter int unsigned FLASH_TICKS = 5,
  localparam int unsigned KEY_W      = $clog2(NUM_KEYS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic [NUM_KEYS-1:0]            down,
  input  logic [2:0]                     slow,
  input  logic [3:0]                     start,
  output logic                           add,
  output logic                           wrong,
  output logic                           hit_pulse,
  output logic                           miss_pulse,
  output logic [15:0]                    hit_cnt,
  output logic [15:0]                    miss_cnt,
  output logic [NUM_SLOTS-1:0]           slot_valid,
  output logic [NUM_SLOTS*KEY_W-1:0]     slot_key,
  output logic [NUM_SLOTS*COORD_W-1:0]   block_x,
  output logic [NUM_SLOTS*COORD_W-1:0]   block_y
);

  localparam int unsigned DIV_W = $clog2(TICK_BASE * 7);
  localparam int unsigned SP_W  = $clog2(SPAWN_GAP + 1);
  localparam int unsigned FL_W  = $clog2(FLASH_TICKS + 1);
  localparam logic [SP_W-1:0]    SpLast = SP_W'(SPAWN_GAP - 1);
  localparam logic [COORD_W:0]   YStep  = (COORD_W + 1)'(Y_STEP);
  localparam logic [COORD_W:0]   YHit   = (COORD_W + 1)'(Y_HIT);

  typedef enum logic [1:0] {StFree, StFall, StFlashHit, StFlashMiss} slot_st_e;

  slot_st_e           st_q  [NUM_SLOTS];
  slot_st_e           st_d  [NUM_SLOTS];
  logic [KEY_W-1:0]   key_q [NUM_SLOTS];
  logic [KEY_W-1:0]   key_d [NUM_SLOTS];
  logic [COORD_W-1:0] x_q   [NUM_SLOTS];
  logic [COORD_W-1:0] x_d   [NUM_SLOTS];
  logic [COORD_W-1:0] y_q   [NUM_SLOTS];
  logic [COORD_W-1:0] y_d   [NUM_SLOTS];
  logic [COORD_W:0]   y_sum [NUM_SLOTS];
  logic [FL_W-1:0]    fl_q  [NUM_SLOTS];
  logic [FL_W-1:0]    fl_d  [NUM_SLOTS];

  logic [DIV_W-1:0]     div_q, div_d, div_last;
  logic [2:0]           slow_eff;
  logic                 tick;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic [KEY_W-1:0]     pkey_q, pkey_d, key_next;
  logic [2:0]           k_q, k_d;
  logic [NUM_SLOTS-1:0] free_vec, spawn_oh, judge_hit, judge_miss;
  logic                 do_spawn;
  logic [15:0]          n_hit, n_miss, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [16:0]          hit_sum, miss_sum;
  logic                 add_q, add_d, wrong_q, wrong_d, hp_q, hp_d, mp_q, mp_d;
  logic [NUM_KEYS-1:0]  judge_src;

  assign slow_eff = (slow == 3'd0) ? 3'd1 : slow;
  // Compare against the live slow value so a change lands at the next compare.
  assign div_last = DIV_W'(TICK_BASE * 32'(slow_eff) - 32'd1);
  assign tick     = (div_q >= div_last);
  assign div_d    = tick ? '0 : div_q + DIV_W'(1);

  assign key_next = KEY_W'(32'(pkey_q) + 32'(k_q) * 32'(k_q) + 32'(start));

`ifdef KEY_EDGE_EN
  logic [NUM_KEYS-1:0] down_q, rise, latch_q, latch_d;
  assign rise      = down & ~down_q;
  assign latch_d   = tick ? rise : (latch_q | rise);
  assign judge_src = latch_q | rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      down_q  <= '0;
      latch_q <= '0;
    end else if (ena) begin
      down_q  <= down;
      latch_q <= latch_d;
    end
  end
`else
  assign judge_src = down;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) free_vec[i] = (st_q[i] == StFree);
    // Lowest set bit picks the lowest-index free slot.
    spawn_oh = free_vec & (~free_vec + NUM_SLOTS'(1));
    do_spawn = tick && (sp_q == SpLast) && (|free_vec);
    sp_d     = sp_q;
    if (tick && (sp_q != SpLast)) sp_d = sp_q + SP_W'(1);
    else if (do_spawn)            sp_d = '0;
    pkey_d = do_spawn ? key_next : pkey_q;
    k_d    = do_spawn ? k_q + 3'd1 : k_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_d[i]       = st_q[i];
      key_d[i]      = key_q[i];
      x_d[i]        = x_q[i];
      y_d[i]        = y_q[i];
      fl_d[i]       = fl_q[i];
      y_sum[i]      = {1'b0, y_q[i]} + YStep;
      judge_hit[i]  = 1'b0;
      judge_miss[i] = 1'b0;
      if (tick) begin
        unique case (st_q[i])
          StFree: begin
            if (do_spawn && spawn_oh[i]) begin
              st_d[i]  = StFall;
              key_d[i] = key_next;
              x_d[i]   = COORD_W'(X_ORIGIN + 32'(key_next) * X_PITCH);
              y_d[i]   = COORD_W'(Y_START);
            end
          end
          StFall: begin
            if (y_sum[i] >= YHit) begin
              y_d[i]        = YHit[COORD_W-1:0];
              fl_d[i]       = FL_W'(FLASH_TICKS - 1);
              judge_hit[i]  = judge_src[key_q[i]];
              judge_miss[i] = ~judge_src[key_q[i]];
              st_d[i]       = judge_src[key_q[i]] ? StFlashHit : StFlashMiss;
            end else begin
              y_d[i] = y_sum[i][COORD_W-1:0];
            end
          end
          StFlashHit, StFlashMiss: begin
            if (fl_q[i] == '0) st_d[i] = StFree;
            else               fl_d[i] = fl_q[i] - FL_W'(1);
          end
        endcase
      end
    end
  end

  always_comb begin
    n_hit   = '0;
    n_miss  = '0;
    add_d   = 1'b0;
    wrong_d = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n_hit  = n_hit + 16'(judge_hit[i]);
      n_miss = n_miss + 16'(judge_miss[i]);
      if (st_d[i] == StFlashHit)  add_d   = 1'b1;
      if (st_d[i] == StFlashMiss) wrong_d = 1'b1;
    end
    hit_sum    = {1'b0, hit_cnt_q} + {1'b0, n_hit};
    miss_sum   = {1'b0, miss_cnt_q} + {1'b0, n_miss};
    hit_cnt_d  = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    miss_cnt_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    hp_d       = tick && (n_hit != '0);
    mp_d       = tick && (n_miss != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      sp_q       <= SpLast;
      pkey_q     <= '0;
      k_q        <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      add_q      <= 1'b0;
      wrong_q    <= 1'b0;
      hp_q       <= 1'b0;
      mp_q       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]  <= StFree;
        key_q[i] <= '0;
        x_q[i]   <= COORD_W'(X_ORIGIN);
        y_q[i]   <= COORD_W'(Y_START);
        fl_q[i]  <= '0;
      end
    end else if (ena) begin
      div_q      <= div_d;
      sp_q       <= sp_d;
      pkey_q     <= pkey_d;
      k_q        <= k_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      add_q      <= add_d;
      wrong_q    <= wrong_d;
      hp_q       <= hp_d;
      mp_q       <= mp_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i]  <= st_d[i];
        key_q[i] <= key_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        fl_q[i]  <= fl_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign slot_valid[g]                   = (st_q[g] != StFree);
    assign slot_key[g*KEY_W +: KEY_W]      = key_q[g];
    assign block_x[g*COORD_W +: COORD_W]   = x_q[g];
    assign block_y[g*COORD_W +: COORD_W]   = y_q[g];
  end

  assign add        = add_q;
  assign wrong      = wrong_q;
  assign hit_pulse  = hp_q;
  assign miss_pulse = mp_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_block_move_multi.sv
// Bench for block_move_multi: age-based slot model checked every cycle, plus hand-computed points.
module tb_block_move_multi;
  localparam int NK = 16, NS = 2, KW = 4, CW = 16;
  localparam int XO = 163, XP = 40, YS = 5, YH = 11, YST = 2;
  localparam int TB = 4, GAP = 1, FL = 5;
  // Ticks from spawn until the block reaches the hit line.
  localparam int JUDGE_AGE = (YH - YS + YST - 1) / YST;

  logic clk = 1'b0;
  logic rst, ena;
  logic [NK-1:0] down;
  logic [2:0] slow;
  logic [3:0] start;
  logic add, wrong, hit_pulse, miss_pulse;
  logic [15:0] hit_cnt, miss_cnt;
  logic [NS-1:0] slot_valid;
  logic [NS*KW-1:0] slot_key;
  logic [NS*CW-1:0] block_x, block_y;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  block_move_multi #(
    .NUM_KEYS(NK), .NUM_SLOTS(NS), .COORD_W(CW), .X_ORIGIN(XO), .X_PITCH(XP),
    .Y_START(YS), .Y_HIT(YH), .Y_STEP(YST), .TICK_BASE(TB), .SPAWN_GAP(GAP),
    .FLASH_TICKS(FL)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .down(down), .slow(slow), .start(start),
    .add(add), .wrong(wrong), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .slot_valid(slot_valid),
    .slot_key(slot_key), .block_x(block_x), .block_y(block_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each slot is described by its spawn tick; everything else follows from age.
  int m_div, m_tick, m_gap, m_key, m_k, m_hc, m_mc, nh, nm, per, age;
  bit m_hp, m_mp, spawned;
  bit m_busy[NS], m_used[NS], m_hit[NS], snap_free[NS];
  int m_born[NS], m_skey[NS];

  always @(posedge clk) begin
    if (!rst) begin
      m_div = 0; m_tick = 0; m_gap = GAP - 1; m_key = 0; m_k = 0;
      m_hc = 0; m_mc = 0; m_hp = 0; m_mp = 0;
      for (int s = 0; s < NS; s++) begin
        m_busy[s] = 0; m_used[s] = 0; m_hit[s] = 0; m_born[s] = 0; m_skey[s] = 0;
      end
    end else if (ena) begin
      per = TB * ((slow == 3'd0) ? 1 : int'(slow));
      if (m_div < per - 1) begin
        m_div++; m_hp = 0; m_mp = 0;
      end else begin
        m_div = 0; m_tick++; nh = 0; nm = 0; spawned = 0;
        for (int s = 0; s < NS; s++) snap_free[s] = !m_busy[s];
        for (int s = 0; s < NS; s++) begin
          if (m_busy[s]) begin
            age = m_tick - m_born[s];
            if (age == JUDGE_AGE) begin
              m_hit[s] = down[m_skey[s]];
              if (m_hit[s]) nh++; else nm++;
            end else if (age == JUDGE_AGE + FL) begin
              m_busy[s] = 0;
            end
          end
        end
        if (m_gap >= GAP - 1) begin
          for (int s = 0; s < NS; s++) begin
            if (!spawned && snap_free[s]) begin
              m_key = (m_key + m_k * m_k + int'(start)) % NK;
              m_k = (m_k + 1) % 8;
              m_busy[s] = 1; m_used[s] = 1; m_hit[s] = 0;
              m_born[s] = m_tick; m_skey[s] = m_key;
              spawned = 1; m_gap = 0;
            end
          end
        end else begin
          m_gap++;
        end
        m_hc = (m_hc + nh > 65535) ? 65535 : m_hc + nh;
        m_mc = (m_mc + nm > 65535) ? 65535 : m_mc + nm;
        m_hp = (nh > 0); m_mp = (nm > 0);
      end
    end
  end

  logic [NS-1:0] e_valid;
  logic [NS*KW-1:0] e_key;
  logic [NS*CW-1:0] e_x, e_y;
  logic e_add, e_wrong;
  int c_age, c_y;

  always @(negedge clk) begin
    if (started) begin
      e_valid = '0; e_key = '0; e_x = '0; e_y = '0; e_add = 0; e_wrong = 0;
      for (int s = 0; s < NS; s++) begin
        c_age = m_tick - m_born[s];
        c_y = YS + c_age * YST;
        if (c_y > YH) c_y = YH;
        if (!m_used[s]) c_y = YS;
        e_valid[s] = m_busy[s];
        e_key[s*KW +: KW] = KW'(m_skey[s]);
        e_x[s*CW +: CW] = CW'(XO + m_skey[s] * XP);
        e_y[s*CW +: CW] = CW'(c_y);
        if (m_busy[s] && c_age >= JUDGE_AGE) begin
          if (m_hit[s]) e_add = 1; else e_wrong = 1;
        end
      end
      chk("cyc add", add, e_add);
      chk("cyc wrong", wrong, e_wrong);
      chk("cyc hit_pulse", hit_pulse, m_hp);
      chk("cyc miss_pulse", miss_pulse, m_mp);
      chk("cyc hit_cnt", hit_cnt, m_hc);
      chk("cyc miss_cnt", miss_cnt, m_mc);
      chk("cyc slot_valid", slot_valid, e_valid);
      chk("cyc slot_key", slot_key, e_key);
      chk("cyc block_x", block_x, e_x);
      chk("cyc block_y", block_y, e_y);
    end
  end

  task automatic tick_wait(input int n);
    repeat (n * TB) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; down = '0; slow = 3'd1; start = 4'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    started = 1'b1;
    chk("rst valid", slot_valid, 2'b00);
    chk("rst x", block_x, {16'd163, 16'd163});
    chk("rst y", block_y, {16'd5, 16'd5});
    chk("rst hit_cnt", hit_cnt, 16'd0);
    chk("rst add", add, 1'b0);
    rst = 1'b1; down = 16'h4008;
    repeat (3) @(negedge clk);
    chk("pre-tick valid", slot_valid, 2'b00);
    @(negedge clk);
    chk("t1 valid", slot_valid, 2'b01);
    chk("t1 key0", slot_key[3:0], 4'd3);
    chk("t1 x0", block_x[15:0], 16'd283);
    chk("t1 y0", block_y[15:0], 16'd5);
    tick_wait(1);
    chk("t2 valid", slot_valid, 2'b11);
    chk("t2 key1", slot_key[7:4], 4'd7);
    chk("t2 x1", block_x[31:16], 16'd443);
    chk("t2 y0", block_y[15:0], 16'd7);
    tick_wait(2);
    chk("t4 y0", block_y[15:0], 16'd11);
    chk("t4 add", add, 1'b1);
    chk("t4 hit_pulse", hit_pulse, 1'b1);
    chk("t4 hit_cnt", hit_cnt, 16'd1);
    chk("t4 wrong", wrong, 1'b0);
    @(negedge clk);
    chk("t4+1 hit_pulse", hit_pulse, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5 miss_pulse", miss_pulse, 1'b1);
    chk("t5 miss_cnt", miss_cnt, 16'd1);
    chk("t5 wrong", wrong, 1'b1);
    chk("t5 add", add, 1'b1);
    chk("t5 y1", block_y[31:16], 16'd11);
    tick_wait(4);
    chk("t9 valid", slot_valid, 2'b10);
    chk("t9 add", add, 1'b0);
    chk("t9 wrong", wrong, 1'b1);
    tick_wait(1);
    chk("t10 valid", slot_valid, 2'b01);
    chk("t10 key0", slot_key[3:0], 4'd14);
    chk("t10 x0", block_x[15:0], 16'd723);
    chk("t10 wrong", wrong, 1'b0);
    tick_wait(1);
    chk("t11 valid", slot_valid, 2'b11);
    chk("t11 key1", slot_key[7:4], 4'd10);
    chk("t11 x1", block_x[31:16], 16'd563);
    ena = 1'b0;
    repeat (100) @(negedge clk);
    chk("frz valid", slot_valid, 2'b11);
    chk("frz y", block_y, {16'd5, 16'd7});
    chk("frz hit_cnt", hit_cnt, 16'd1);
    chk("frz miss_cnt", miss_cnt, 16'd1);
    ena = 1'b1;
    tick_wait(2);
    chk("t13 add", add, 1'b1);
    chk("t13 hit_cnt", hit_cnt, 16'd2);
    tick_wait(1);
    chk("t14 miss_cnt", miss_cnt, 16'd2);
    chk("t14 wrong", wrong, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid-rst add", add, 1'b0);
    chk("mid-rst hit_cnt", hit_cnt, 16'd0);
    chk("mid-rst miss_cnt", miss_cnt, 16'd0);
    chk("mid-rst valid", slot_valid, 2'b00);
    slow = 3'd2; start = 4'd9; rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("slow2 valid", slot_valid, 2'b01);
    chk("slow2 key0", slot_key[3:0], 4'd9);
    chk("slow2 x0", block_x[15:0], 16'd523);
    down = 16'hFFFF;
    repeat (96) @(negedge clk);
    slow = 3'd0; down = 16'h00FF;
    repeat (80) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/block_move_multi.md
Name: block_move_multi

Overview:
- Next-generation falling-block engine for the piano game.
- Runs NUM_SLOTS independent falling blocks at once over NUM_KEYS key lanes.
- Judges each block against the key state when it reaches the hit line, and accumulates hit/miss scores.
- Sits between the keyboard scanner (down) and the VGA renderer (block_x/block_y per slot), with the score display consuming hit_cnt/miss_cnt.

Parameters:
- NUM_KEYS, 16: key lanes; power of two; KEY_W = clog2(NUM_KEYS).
- NUM_SLOTS, 4: concurrent blocks.
- COORD_W, 16: width of each coordinate.
- X_ORIGIN, 163: x of lane 0.
- X_PITCH, 40: x spacing between lanes.
- Y_START, 5: y loaded on spawn.
- Y_HIT, 305: judgement line.
- Y_STEP, 2: y increment per tick.
- TICK_BASE, 250000: clk cycles per tick at slow=1.
- SPAWN_GAP, 40: ticks between spawn attempts.
- FLASH_TICKS, 5: ticks a judged block stays displayed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- ena  in  1  run enable; low freezes all state
- down  in  NUM_KEYS  key-pressed levels
- slow  in  3  speed divider; 0 treated as 1
- start  in  4  pattern seed/offset
- add  out  1  high while any slot is in FLASH_HIT
- wrong  out  1  high while any slot is in FLASH_MISS
- hit_pulse  out  1  one-cycle pulse on a tick with ≥1 hit
- miss_pulse  out  1  one-cycle pulse on a tick with ≥1 miss
- hit_cnt  out  16  saturating hit count
- miss_cnt  out  16  saturating miss count
- slot_valid  out  NUM_SLOTS  slot not FREE
- slot_key  out  NUM_SLOTS*KEY_W  lane per slot; slot i at bits [i*KEY_W +: KEY_W]
- block_x  out  NUM_SLOTS*COORD_W  x per slot, same packing
- block_y  out  NUM_SLOTS*COORD_W  y per slot, same packing

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; it takes effect only at a clk edge and overrides ena.
- Reset values (also applied on reset mid-operation):
  - all slots FREE; slot_key=0; block_x=X_ORIGIN; block_y=Y_START
  - add=0, wrong=0, pulses=0, counters=0
  - tick counter=0, pattern key=0, pattern k=0
  - spawn counter=SPAWN_GAP-1, so the first spawn happens on the first tick.
- Tick generation:
  - divider counts 0..TICK_BASE*max(slow,1)-1 while ena=1; tick is high for the one cycle at terminal count, then the divider wraps to 0.
  - A slow change takes effect at the next compare.
  - ena=0 holds every register.
- Slot FSM, evaluated only on tick cycles:
  - FREE: loaded only by spawn.
  - FALL, y+Y_STEP < Y_HIT: y += Y_STEP.
  - FALL, y+Y_STEP >= Y_HIT: y is set to Y_HIT and the slot is judged in the same tick. down[key]=1 gives FLASH_HIT; otherwise FLASH_MISS. The flash counter is loaded with FLASH_TICKS-1.
  - FLASH_HIT / FLASH_MISS: counter decrements; at 0 the slot goes FREE. x and y hold during flash.
- Spawn, on a tick:
  - if spawn counter==SPAWN_GAP-1 and any slot was FREE at the start of that tick, the lowest-index FREE slot is loaded and the spawn counter goes to 0.
  - If no slot is FREE, the counter holds at terminal and spawn is retried every tick.
  - A slot freed in tick T is not reusable until tick T+1.
  - Otherwise the spawn counter increments.
- Pattern generator:
  - key_next = (key + k*k + start) mod NUM_KEYS, computed at full width and then truncated; k is 3-bit and wraps 7 -> 0 after each spawn.
  - The loaded slot takes key_next: x = X_ORIGIN + key_next*X_PITCH, y = Y_START.
- Scoring:
  - judgements in one tick are counted by popcount; hit_cnt += number of hits, miss_cnt += number of misses.
  - Counters saturate at 16'hFFFF.
  - hit_pulse/miss_pulse assert in the cycle after the judging tick edge, for 1 cycle.
- Latency: outputs are registered and change in the cycle after the tick edge that causes them.

Optional Feature:
- Macro KEY_EDGE_EN.
- Defined:
  - down is registered, and a per-key rise latch sets on each 0->1 transition.
  - The latch clears at every tick edge unless set in that same cycle.
  - A judgement is a hit only if the lane's latch is set, so a held key does not score.
- Undefined: no latch; level sample of down[key] at the judging tick.

Test Plan:
- Reset: TICK_BASE=4, slow=1, ena=1, rst=0 for 3 cycles then 1.
  - During reset: all outputs hold reset values.
  - First tick at cycle 4 after release: slot 0 valid, slot_key=start, x=X_ORIGIN+start*40, y=5.
- Fall and hit: Y_HIT=11, Y_STEP=2, hold down[key]=1.
  - y goes 5,7,9,11 on successive ticks.
  - At the 11 tick: add=1, hit_pulse for one cycle, hit_cnt=1.
  - After 5 more ticks: slot_valid[0]=0, add=0.
- Miss: same setup, down=0 -> wrong=1, miss_cnt=1, add stays 0.
- Slot exhaustion: NUM_SLOTS=2, SPAWN_GAP=1, long fall.
  - Slots 0 and 1 are filled on ticks 1 and 2; no spawn while both are busy.
  - Spawn occurs on the tick after the first slot frees.
- Simultaneous judgement: two slots judged in the same tick, one key down and one up -> hit_cnt+1 and miss_cnt+1 in the same cycle; add=1 and wrong=1 together.
- Freeze/reset mid-run:
  - ena=0 for 100 cycles -> all outputs unchanged.
  - rst=0 during FLASH_HIT -> add=0, counters=0, all slots FREE at the next edge.
